aes_io_bridge: RTL and testbench
================================

# aes_io_bridge

Host-side register bridge sitting directly upstream of the AES decryption controller. It assembles the 128-bit cipher key and 128-bit encrypted message from 32-bit host writes and drives the controller's `io_ready` request. It captures the 128-bit decrypted result when the controller raises `aes_ready`, then exposes the result and the run status for 32-bit host reads.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of RUN cycles without `aes_ready` before the bridge aborts. Used only when the watchdog is compiled in.

Ports:
- `Clk`  in  1  system clock, rising-edge.
- `Reset`  in  1  synchronous, active-high reset. One clock domain. The same net, inverted, drives the controller's `reset_n`.
- `wr_en`  in  1  host write strobe.
- `rd_en`  in  1  host read strobe.
- `addr`  in  4  word address.
- `wr_data`  in  32  host write data.
- `rd_data`  out  32  registered host read data.
- `msg_en`  out  128  encrypted message to the controller.
- `key`  out  128  cipher key to the controller.
- `io_ready`  out  1  run request to the controller.
- `msg_de`  in  128  decrypted result from the controller.
- `aes_ready`  in  1  controller result-valid indication.
- `busy`  out  1  high when the FSM is not in IDLE.
- `done`  out  1  sticky result-available flag.

## Operation
- Address map (word 0 of each group = bits 127:96):
  - 0–3: key.
  - 4–7: msg_en.
  - 8–11: result (read-only).
  - 12: CTRL (write-only). Bit 0 = start, bit 1 = clear done.
  - 13: STATUS (read-only). Bit 0 = busy, bit 1 = done, bit 2 = timeout.
  - 14–15: reserved. Reads return 0; writes are ignored.
- Key and message writes are accepted only in IDLE. While busy they are silently dropped, so the controller inputs stay stable for the whole run.
- FSM states: IDLE, RUN, RELEASE.
  - IDLE -> RUN on a CTRL write with bit 0 = 1. This also clears `done` and `timeout`.
  - RUN: `io_ready` = 1. On `aes_ready` = 1, latch `msg_de` into the result register and go to RELEASE.
  - RELEASE: `io_ready` = 0. Wait for `aes_ready` = 0 (the controller has returned to WAIT), then set `done` and go to IDLE.
- A start write while busy is ignored. A clear-done write is honoured in any state.
- Simultaneous start and clear-done in IDLE: clear first, then start. The net result is RUN with `done` = 0.
- Reset values: every output is 0. Key, message, result, `done`, `timeout`, and the cycle counter are all 0. The FSM is in IDLE.
- Reset mid-run: the bridge returns to IDLE on the next edge. The controller resets on the same net, so no stale handshake survives.

## Timing
- Register write at edge t: the value is visible on `key`/`msg_en` after edge t.
- Start write at edge t: `io_ready` and `busy` are high from edge t.
- `aes_ready` sampled high at edge t:
  - result register holds `msg_de` after edge t;
  - `io_ready` is low after edge t.
- `done` rises one edge after `aes_ready` is sampled low in RELEASE.
- End-to-end from start: the controller's fixed sequence plus 2 cycles.
- Read latency is 1 cycle: `rd_en` at edge t drives `rd_data` after edge t. `rd_data` holds its value when `rd_en` = 0.
- Simultaneous read and write of the same address returns the old value.

## Configuration
- Macro: `AES_IO_TIMEOUT_EN`.
- Defined: an 8-bit-or-wider cycle counter runs in RUN.
  - When it reaches `TIMEOUT_CYCLES` without `aes_ready`, the bridge sets `timeout`, leaves the result unchanged, and goes to RELEASE (`done` is still set on exit).
  - The counter clears on entry to RUN.
- Undefined: no counter exists, STATUS bit 2 reads 0, RUN waits indefinitely, and `TIMEOUT_CYCLES` is unused.

## Structure
- Package `aes_io_pkg` holds:
  - the address constants (`ADDR_KEY0`, `ADDR_MSG0`, `ADDR_RES0`, `ADDR_CTRL`, `ADDR_STATUS`);
  - the CTRL and STATUS bit indices;
  - the FSM state enum `aes_io_state_t`.
- Sub-module `aes_word_reg128`: a 128-bit register loaded one 32-bit word at a time, with a write enable, a 2-bit word index, and a lock input. It is instantiated for key and msg_en.

## Test plan
- Write key `000102…0F` and message `DAA08136…` to words 0–7, then start. Expect:
  - `key`/`msg_en` match;
  - `io_ready` = 1 one cycle after the start write;
  - result words 8–11 equal the known plaintext after completion;
  - STATUS = 0x2.
- Drive `aes_ready` = 1 at cycle 60, hold it until `io_ready` falls, then release it 3 cycles later. Expect:
  - result latched at cycle 61;
  - `done` = 1 exactly one cycle after `aes_ready` = 0.
- While busy, write 0xFFFFFFFF to word 0 and issue a second start. Expect `key`[127:96] unchanged and only one run.
- Assert `Reset` mid-RUN at cycle 20. Expect all outputs 0 next cycle and STATUS = 0. A new start then completes normally.
- With `AES_IO_TIMEOUT_EN` defined and `TIMEOUT_CYCLES` = 10, never assert `aes_ready`. Expect:
  - `io_ready` falls after 10 RUN cycles;
  - STATUS = 0x6;
  - result unchanged.
- Read address 8 in the same cycle that `aes_ready` is latched. Expect the old result; the next read returns the new result.

Source files
------------

// File: rtl/aes_io_pkg.sv
// rtl/aes_io_pkg.sv - address map, control/status bit indices and FSM states for aes_io_bridge
package aes_io_pkg;

    localparam logic [3:0] ADDR_KEY0   = 4'd0;
    localparam logic [3:0] ADDR_MSG0   = 4'd4;
    localparam logic [3:0] ADDR_RES0   = 4'd8;
    localparam logic [3:0] ADDR_CTRL   = 4'd12;
    localparam logic [3:0] ADDR_STATUS = 4'd13;

    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } aes_io_state_t;

    // Word 0 of a 128-bit group is the most significant word.
    function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] idx);
        return v[{~idx, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/aes_word_reg128.sv
// rtl/aes_word_reg128.sv - 128-bit register loaded one 32-bit word at a time, word 0 = bits 127:96
module aes_word_reg128
    import aes_io_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [1:0]   idx,
    input  logic         lock,
    input  logic [31:0]  wr_data,
    output logic [127:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (wr_en && !lock) begin
            q[{~idx, 5'b0} +: 32] <= wr_data;
        end
    end

endmodule

// File: rtl/aes_io_bridge.sv
// rtl/aes_io_bridge.sv - host register bridge in front of the AES decryption controller
// Optional run watchdog compiled in with AES_IO_TIMEOUT_EN.
module aes_io_bridge
    import aes_io_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [3:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [127:0] msg_en,
    output logic [127:0] key,
    output logic         io_ready,
    input  logic [127:0] msg_de,
    input  logic         aes_ready,
    output logic         busy,
    output logic         done
);

    aes_io_state_t state;
    logic [127:0]  result;
    logic          timeout;
    logic [31:0]   status;

    logic ctrl_wr;
    logic key_we;
    logic msg_we;

    assign ctrl_wr = wr_en && (addr == ADDR_CTRL);
    assign key_we  = wr_en && (addr[3:2] == ADDR_KEY0[3:2]);
    assign msg_we  = wr_en && (addr[3:2] == ADDR_MSG0[3:2]);

    // Locking on busy keeps the controller inputs frozen for the whole run.
    aes_word_reg128 u_key (
        .clk     (Clk),
        .reset   (Reset),
        .wr_en   (key_we),
        .idx     (addr[1:0]),
        .lock    (busy),
        .wr_data (wr_data),
        .q       (key)
    );

    aes_word_reg128 u_msg (
        .clk     (Clk),
        .reset   (Reset),
        .wr_en   (msg_we),
        .idx     (addr[1:0]),
        .lock    (busy),
        .wr_data (wr_data),
        .q       (msg_en)
    );

`ifdef AES_IO_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            io_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            result   <= '0;
`ifdef AES_IO_TIMEOUT_EN
            cnt      <= '0;
`endif
        end else begin
            if (ctrl_wr && wr_data[CTRL_CLR_DONE]) begin
                done <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (ctrl_wr && wr_data[CTRL_START]) begin
                        state    <= ST_RUN;
                        io_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        timeout  <= 1'b0;
`ifdef AES_IO_TIMEOUT_EN
                        cnt      <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (aes_ready) begin
                        result   <= msg_de;
                        io_ready <= 1'b0;
                        state    <= ST_RELEASE;
                    end
`ifdef AES_IO_TIMEOUT_EN
                    else if (cnt == CNT_LAST) begin
                        timeout  <= 1'b1;
                        io_ready <= 1'b0;
                        state    <= ST_RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                ST_RELEASE: begin
                    // Completion is only reported once the controller is back in WAIT.
                    if (!aes_ready) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        status               = '0;
        status[STAT_BUSY]    = busy;
        status[STAT_DONE]    = done;
        status[STAT_TIMEOUT] = timeout;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (addr[3:2] == ADDR_KEY0[3:2]) begin
                rd_data <= word_sel(key, addr[1:0]);
            end else if (addr[3:2] == ADDR_MSG0[3:2]) begin
                rd_data <= word_sel(msg_en, addr[1:0]);
            end else if (addr[3:2] == ADDR_RES0[3:2]) begin
                rd_data <= word_sel(result, addr[1:0]);
            end else if (addr == ADDR_STATUS) begin
                rd_data <= status;
            end else begin
                rd_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_aes_io_bridge.sv
// tb/tb_aes_io_bridge.sv - directed self-checking bench for aes_io_bridge
module tb_aes_io_bridge;

    localparam logic [127:0] KEY   = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] MSG   = 128'hDAA08136_5A1B2C3D_4E5F6071_8293A4B5;
    localparam logic [127:0] PLAIN = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] KEY2  = 128'hA5A5A5A5_11112222_33334444_55556666;
    localparam logic [127:0] PLAIN2 = 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [3:0]   addr = 4'd0;
    logic [31:0]  wr_data = 32'd0;
    logic [31:0]  rd_data;
    logic [127:0] msg_en;
    logic [127:0] key;
    logic         io_ready;
    logic [127:0] msg_de = '0;
    logic         aes_ready = 1'b0;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    aes_io_bridge #(.TIMEOUT_CYCLES(10)) dut (
        .Clk       (clk),
        .Reset     (reset),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .msg_en    (msg_en),
        .key       (key),
        .io_ready  (io_ready),
        .msg_de    (msg_de),
        .aes_ready (aes_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [31:0] d);
        addr = a; wr_data = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic host_rd(input logic [3:0] a, output logic [31:0] d);
        addr = a; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic load_block(input logic [3:0] base, input logic [127:0] v);
        for (int i = 0; i < 4; i++) begin
            host_wr(base + 4'(i), v[127 - 32*i -: 32]);
        end
    endtask

    task automatic finish_run(input logic [127:0] res);
        aes_ready = 1'b1; msg_de = res;
        tick();
        aes_ready = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        check("run_completes", busy, 1'b0);
    endtask

    logic [31:0] rd;
    int          hi_cycles;

    initial begin
        repeat (2) tick();
        check("rst_key", key, '0);
        check("rst_msg", msg_en, '0);
        check("rst_io_ready", io_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_data", rd_data, '0);
        reset = 1'b0;
        tick();

        load_block(4'd0, KEY);
        load_block(4'd4, MSG);
        check("key_loaded", key, KEY);
        check("msg_loaded", msg_en, MSG);
        host_rd(4'd1, rd);
        check("key_word1_read", rd, 32'h04050607);
        host_rd(4'd4, rd);
        check("msg_word0_read", rd, 32'hDAA08136);

        host_wr(4'd12, 32'h1);
        check("start_io_ready", io_ready, 1'b1);
        check("start_busy", busy, 1'b1);

        host_wr(4'd0, 32'hFFFFFFFF);
        host_wr(4'd12, 32'h1);
        check("busy_key_locked", key[127:96], 32'h00010203);
        check("busy_key_whole", key, KEY);

        repeat (55) tick();
        check("run_io_ready_held", io_ready, 1'b1);

        // Latch the result while reading the old result in the same edge.
        aes_ready = 1'b1; msg_de = PLAIN; addr = 4'd8; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("rd_old_result", rd_data, 32'h0);
        check("io_ready_low_after_latch", io_ready, 1'b0);
        check("busy_in_release", busy, 1'b1);
        msg_de = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;
        host_rd(4'd8, rd);
        check("rd_new_result", rd, 32'h00112233);
        tick();
        check("done_held_low_release", done, 1'b0);
        aes_ready = 1'b0;
        tick();
        check("done_after_release", done, 1'b1);
        check("idle_after_release", busy, 1'b0);

        for (int i = 0; i < 4; i++) begin
            host_rd(4'd8 + 4'(i), rd);
            check($sformatf("result_word%0d", i), rd, PLAIN[127 - 32*i -: 32]);
        end
        host_rd(4'd13, rd);
        check("status_done", rd, 32'h2);
        repeat (5) tick();
        check("single_run", io_ready, 1'b0);

        host_wr(4'd15, 32'hFFFFFFFF);
        host_rd(4'd14, rd);
        check("reserved14_zero", rd, 32'h0);
        host_rd(4'd15, rd);
        check("reserved15_zero", rd, 32'h0);
        host_rd(4'd12, rd);
        check("ctrl_reads_zero", rd, 32'h0);

        host_wr(4'd12, 32'h3);
        check("start_clear_busy", busy, 1'b1);
        check("start_clear_done", done, 1'b0);
        repeat (18) tick();
        reset = 1'b1;
        tick();
        check("midrun_rst_key", key, '0);
        check("midrun_rst_msg", msg_en, '0);
        check("midrun_rst_io_ready", io_ready, 1'b0);
        check("midrun_rst_busy", busy, 1'b0);
        check("midrun_rst_done", done, 1'b0);
        check("midrun_rst_rd", rd_data, '0);
        reset = 1'b0;
        host_rd(4'd13, rd);
        check("status_after_reset", rd, 32'h0);
        host_rd(4'd8, rd);
        check("result_after_reset", rd, 32'h0);

        load_block(4'd0, KEY2);
        check("key2_loaded", key, KEY2);
        host_wr(4'd12, 32'h1);
        repeat (7) tick();
        finish_run(PLAIN2);
        host_rd(4'd11, rd);
        check("rerun_result_word3", rd, 32'h89ABCDEF);
        host_rd(4'd13, rd);
        check("rerun_status", rd, 32'h2);

`ifdef AES_IO_TIMEOUT_EN
        host_wr(4'd12, 32'h1);
        hi_cycles = 0;
        for (int i = 0; i < 100 && io_ready; i++) begin
            hi_cycles++;
            tick();
        end
        check("timeout_run_cycles", 32'(hi_cycles), 32'd10);
        for (int i = 0; i < 10 && busy; i++) tick();
        host_rd(4'd13, rd);
        check("timeout_status", rd, 32'h6);
        host_rd(4'd8, rd);
        check("timeout_result_kept", rd, 32'hCAFEF00D);
`else
        host_wr(4'd12, 32'h1);
        hi_cycles = 0;
        for (int i = 0; i < 300; i++) begin
            if (io_ready) hi_cycles++;
            tick();
        end
        check("no_watchdog_waits", 32'(hi_cycles), 32'd300);
        host_rd(4'd13, rd);
        check("no_watchdog_status", rd, 32'h1);
        finish_run(PLAIN);
        host_rd(4'd13, rd);
        check("no_watchdog_final_status", rd, 32'h2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
